// File: rtl/pipe_cl_adder.sv
// ============================================================================
// Module   : pipe_cl_adder
// Purpose  : Pipelined segmented carry-lookahead adder with valid/ready flow.
//            Optional macro PIPE_ADDER_SUB_EN adds the sub_i port (A - B).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_cl_adder #(
   parameter int Width    = 32,
   parameter int SegWidth = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   input  logic             c_i,
`ifdef PIPE_ADDER_SUB_EN
   input  logic             sub_i,
`endif
   output logic             valid_o,
   input  logic             ready_i,
   output logic [Width-1:0] sum_o,
   output logic             c_o,
   output logic             ovf_o
);

   localparam int NumSeg = Width / SegWidth;

   if ((SegWidth < 1) || ((Width % SegWidth) != 0)) begin : g_bad_cfg
      $error("pipe_cl_adder: Width must be a non-zero multiple of SegWidth");
   end

   // Returns {carry into segment MSB, carry out, segment sum}.
   function automatic logic [SegWidth+1:0] cla_seg(
      input logic [SegWidth-1:0] a,
      input logic [SegWidth-1:0] b,
      input logic                cin
   );
      logic [SegWidth:0]   c;
      logic [SegWidth-1:0] g;
      logic [SegWidth-1:0] p;
      logic [SegWidth-1:0] s;
      g    = a & b;
      p    = a | b;
      c[0] = cin;
      for (int i = 0; i < SegWidth; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      s = a ^ b ^ c[SegWidth-1:0];
      return {c[SegWidth-1], c[SegWidth], s};
   endfunction

   logic [Width-1:0]    r_a   [NumSeg];
   logic [Width-1:0]    r_b   [NumSeg];
   logic [Width-1:0]    r_s   [NumSeg];
   logic                r_c   [NumSeg];
   logic                r_v   [NumSeg];
   logic                r_ovf;

   logic [Width-1:0]    w_a_in  [NumSeg];
   logic [Width-1:0]    w_b_in  [NumSeg];
   logic [Width-1:0]    w_s_in  [NumSeg];
   logic [Width-1:0]    w_s_nxt [NumSeg];
   logic [SegWidth-1:0] w_seg   [NumSeg];
   logic                w_c_in  [NumSeg];
   logic                w_v_in  [NumSeg];
   logic                w_cout  [NumSeg];
   logic                w_cmsb  [NumSeg];
   logic [Width-1:0]    w_b0;
   logic                w_c0;
   logic                w_adv;

`ifdef PIPE_ADDER_SUB_EN
   assign w_b0 = sub_i ? ~b_i : b_i;
   assign w_c0 = sub_i ? 1'b1 : c_i;
`else
   assign w_b0 = b_i;
   assign w_c0 = c_i;
`endif

   // The whole pipeline advances as one unit; no per-stage skid.
   assign w_adv   = ~r_v[NumSeg-1] | ready_i;
   assign ready_o = w_adv;
   assign valid_o = r_v[NumSeg-1];
   assign sum_o   = r_s[NumSeg-1];
   assign c_o     = r_c[NumSeg-1];
   assign ovf_o   = r_ovf;

   always_comb begin
      w_a_in[0] = a_i;
      w_b_in[0] = w_b0;
      w_c_in[0] = w_c0;
      w_v_in[0] = valid_i;
      w_s_in[0] = '0;
      for (int k = 1; k < NumSeg; k++) begin
         w_a_in[k] = r_a[k-1];
         w_b_in[k] = r_b[k-1];
         w_c_in[k] = r_c[k-1];
         w_v_in[k] = r_v[k-1];
         w_s_in[k] = r_s[k-1];
      end
      // Finished segments are zero above the current one, so OR-ing places the new segment.
      for (int k = 0; k < NumSeg; k++) begin
         {w_cmsb[k], w_cout[k], w_seg[k]} = cla_seg(w_a_in[k][k*SegWidth +: SegWidth],
                                                    w_b_in[k][k*SegWidth +: SegWidth],
                                                    w_c_in[k]);
         w_s_nxt[k] = w_s_in[k] | (Width'(w_seg[k]) << (k * SegWidth));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NumSeg; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
            r_c[k] <= 1'b0;
            r_v[k] <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < NumSeg; k++) begin
            r_v[k] <= w_v_in[k];
            if (k < NumSeg - 1) begin
               r_a[k] <= w_a_in[k];
               r_b[k] <= w_b_in[k];
               r_s[k] <= w_s_nxt[k];
               r_c[k] <= w_cout[k];
            end else if (w_v_in[k]) begin
               // Output stage loads only real results so outputs hold across bubbles.
               r_s[k] <= w_s_nxt[k];
               r_c[k] <= w_cout[k];
               r_ovf  <= w_cmsb[k] ^ w_cout[k];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipe_cl_adder.sv
// ============================================================================
// Module   : tb_pipe_cl_adder
// Purpose  : Directed self-checking bench for pipe_cl_adder (32/8 config).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_cl_adder;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        c_i = 1'b0;
   logic        sub_i = 1'b0;
   logic        valid_o;
   logic        ready_i = 1'b1;
   logic [31:0] sum_o;
   logic        c_o;
   logic        ovf_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [33:0] exp_q[$];
   logic [33:0] last_out = '0;
   logic [33:0] prev_out = '0;
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b1;

   always #5 clk = ~clk;

   pipe_cl_adder #(.Width(32), .SegWidth(8)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .a_i     (a_i),
      .b_i     (b_i),
      .c_i     (c_i),
`ifdef PIPE_ADDER_SUB_EN
      .sub_i   (sub_i),
`endif
      .valid_o (valid_o),
      .ready_i (ready_i),
      .sum_o   (sum_o),
      .c_o     (c_o),
      .ovf_o   (ovf_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one operation; expected value packed as {ovf, c, sum}.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic s, input logic [33:0] exp);
      int w;
      valid_i = 1'b1;
      a_i = a;
      b_i = b;
      c_i = c;
      sub_i = s;
      #1;
      w = 0;
      while (!ready_o && w < 50) begin
         step();
         #1;
         w++;
      end
      if (!ready_o) check("send_timeout", 64'd1, 64'd0);
      exp_q.push_back(exp);
      step();
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((exp_q.size() != 0 || valid_o) && w < 40) begin
         step();
         w++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   // Output-side monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_i) begin
         last_out   <= '0;
         prev_valid <= 1'b0;
         prev_ready <= 1'b1;
      end else begin
         if (prev_valid && !prev_ready)
            check("stall_hold", {31'd0, valid_o, c_o, ovf_o, sum_o}, {31'd0, 1'b1, prev_out[32], prev_out[33], prev_out[31:0]});
         check("ready_o", 64'(ready_o), 64'(!valid_o || ready_i));
         if (!valid_o)
            check("idle_hold", 64'({ovf_o, c_o, sum_o}), 64'(last_out));
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) check("unexpected_out", 64'({ovf_o, c_o, sum_o}), 64'hdead);
            else check("result", 64'({ovf_o, c_o, sum_o}), 64'(exp_q.pop_front()));
         end
         if (valid_o) last_out <= {ovf_o, c_o, sum_o};
         prev_valid <= valid_o;
         prev_ready <= ready_i;
         prev_out   <= {ovf_o, c_o, sum_o};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] va [6];
      logic [31:0] vb [6];
      logic        vc [6];
      logic [33:0] ve [6];
      logic        ev;
      va[0] = 32'h12345678; vb[0] = 32'h11111111; vc[0] = 0; ve[0] = {1'b0, 1'b0, 32'h23456789};
      va[1] = 32'h80000000; vb[1] = 32'h80000000; vc[1] = 0; ve[1] = {1'b1, 1'b1, 32'h00000000};
      va[2] = 32'hDEADBEEF; vb[2] = 32'h00000001; vc[2] = 0; ve[2] = {1'b0, 1'b0, 32'hDEADBEF0};
      va[3] = 32'h0F0F0F0F; vb[3] = 32'hF0F0F0F0; vc[3] = 1; ve[3] = {1'b0, 1'b1, 32'h00000000};
      va[4] = 32'h7FFFFFFF; vb[4] = 32'h7FFFFFFF; vc[4] = 1; ve[4] = {1'b1, 1'b0, 32'hFFFFFFFF};
      va[5] = 32'h00FF00FF; vb[5] = 32'h00010001; vc[5] = 0; ve[5] = {1'b0, 1'b0, 32'h01000100};

      repeat (3) step();
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_outs", 64'({ovf_o, c_o, sum_o}), 64'd0);
      rst_i = 1'b0;
      #1;
      check("rst_ready", 64'(ready_o), 64'd1);

      // Basic add with explicit latency checks.
      send(32'h000000FF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h00000100});
      for (int i = 0; i < 3; i++) begin
         check("lat_valid_lo", 64'(valid_o), 64'd0);
         check("lat_outs_zero", 64'({ovf_o, c_o, sum_o}), 64'd0);
         step();
      end
      check("lat_valid_hi", 64'(valid_o), 64'd1);
      check("lat_sum", 64'({ovf_o, c_o, sum_o}), 64'({1'b0, 1'b0, 32'h00000100}));
      drain();

      // Carry ripple through every segment, then signed overflow.
      send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, {1'b0, 1'b1, 32'h00000000});
      send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h80000000});
      drain();

      // Six back-to-back ops with a 3-cycle downstream stall mid-stream.
      fork
         begin
            repeat (5) step();
            ready_i = 1'b0;
            #1;
            check("ready_drop", 64'(ready_o), 64'd0);
            repeat (3) step();
            ready_i = 1'b1;
         end
      join_none
      for (int i = 0; i < 6; i++) send(va[i], vb[i], vc[i], 1'b0, ve[i]);
      drain();

      // Bubbles: ops on even cycles; valid_o must mirror that pattern 4 cycles later.
      for (int j = 0; j < 14; j++) begin
         ev = (j >= 4) && (j < 12) && (((j - 4) % 2) == 0);
         check("bubble_valid", 64'(valid_o), 64'(ev));
         valid_i = (j < 8) && ((j % 2) == 0);
         a_i = va[(j/2) % 6];
         b_i = vb[(j/2) % 6];
         c_i = vc[(j/2) % 6];
         sub_i = 1'b0;
         #1;
         if (valid_i && ready_o) exp_q.push_back(ve[(j/2) % 6]);
         step();
      end
      valid_i = 1'b0;
      drain();

      // Reset with three operations in flight.
      send(va[0], vb[0], vc[0], 1'b0, ve[0]);
      send(va[1], vb[1], vc[1], 1'b0, ve[1]);
      send(va[2], vb[2], vc[2], 1'b0, ve[2]);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         check("flush_valid", 64'(valid_o), 64'd0);
         check("flush_outs", 64'({ovf_o, c_o, sum_o}), 64'd0);
         step();
      end

`ifdef PIPE_ADDER_SUB_EN
      send(32'h00000005, 32'h00000007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFFFFFE});
      send(32'h80000000, 32'h00000001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFFFFFF});
      drain();
`endif

      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
